// File: rtl/temp_pkg.sv
// -----------------------------------------------------------------------------
// temp_pkg
// Shared constants for the ADT7420 temperature-to-BCD converter:
//   - FSM state encoding (legacy-style localparam constants)
//   - arithmetic constants for the Celsius / Fahrenheit scaling
//   - conversion latencies for both build variants
//   - dd_step(): one double-dabble iteration (add-3 correction, then shift)
// -----------------------------------------------------------------------------
package temp_pkg;

   localparam int DIGITS          = 4;
   localparam int BCD_BITS        = 13;
   localparam int F_OFFSET_TENTHS = 320;
   localparam int F_MUL           = 18;
   localparam int ROUND_HALF      = 8;

   // Clocks from the accepted strobe edge to the out_valid cycle
   localparam int LAT_C  = 14;
   localparam int LAT_CF = 28;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_PREP_C = 3'd1;
   localparam logic [2:0] ST_BCD_C  = 3'd2;
   localparam logic [2:0] ST_PREP_F = 3'd3;
   localparam logic [2:0] ST_BCD_F  = 3'd4;

   // One double-dabble step: every digit >= 5 gets +3, then the whole
   // 16-bit BCD word shifts left taking in the next binary bit.
   function automatic logic [15:0] dd_step(input logic [15:0] bcd,
                                           input logic        in_bit);
      logic [15:0] adj;
      adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (adj[i*4 +: 4] >= 4'd5) begin
            adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
         end else begin
            adj[i*4 +: 4] = adj[i*4 +: 4];
         end
      end
      return {adj[14:0], in_bit};
   endfunction

endpackage

// File: rtl/bcd_dd13.sv
// -----------------------------------------------------------------------------
// bcd_dd13
// Sequential 13-bit binary to 4-digit BCD converter (double dabble), one
// iteration per clock, 13 iterations per conversion.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       load bin and begin a conversion on the next edge
//   bin         13-bit unsigned binary operand
//   done        high in the cycle whose closing edge performs the last
//               iteration
//   bcd         value the next iteration produces; in the done cycle this
//               is the finished result, so the caller can register it on
//               the same edge the engine finishes (no extra cycle)
// -----------------------------------------------------------------------------
module bcd_dd13
   import temp_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [BCD_BITS-1:0] bin,
   output logic                done,
   output logic [15:0]         bcd
);

   logic [BCD_BITS-1:0] r_bin;
   logic [15:0]         r_bcd;
   logic [3:0]          r_cnt;
   logic [15:0]         w_bcd_nxt;

   // Next BCD value: correct digits, shift in the binary MSB
   always_comb begin
      w_bcd_nxt = dd_step(r_bcd, r_bin[BCD_BITS-1]);
   end

   // Operand shift register, BCD accumulator and iteration counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bin <= '0;
         r_bcd <= 16'd0;
         r_cnt <= 4'd0;
      end else if (start) begin
         r_bin <= bin;
         r_bcd <= 16'd0;
         r_cnt <= 4'd13;
      end else if (r_cnt != 4'd0) begin
         r_bin <= {r_bin[BCD_BITS-2:0], 1'b0};
         r_bcd <= w_bcd_nxt;
         r_cnt <= r_cnt - 4'd1;
      end else begin
         r_bin <= r_bin;
         r_bcd <= r_bcd;
         r_cnt <= r_cnt;
      end
   end

   assign done = (r_cnt == 4'd1);
   assign bcd  = w_bcd_nxt;

endmodule

// File: rtl/temp_bcd_conv.sv
// -----------------------------------------------------------------------------
// temp_bcd_conv
// Converts the raw ADT7420 13-bit temperature register into sign-magnitude
// BCD tenths of a degree Celsius and, optionally, Fahrenheit. One conversion
// per raw_valid strobe; all results load together with a one-cycle out_valid
// and are held until the next conversion completes.
// Build option: define TEMP_FAHRENHEIT_EN to add the Fahrenheit pass
// (latency 28 clocks); without it f_sign/f_bcd are 0 and latency is 14.
// Ports:
//   clk, rst_n  100 MHz clock, asynchronous active-low reset
//   raw         temperature register, bits [15:3] two's complement 1/16 C
//   raw_valid   start strobe, sampled only while idle
//   busy        conversion in progress
//   out_valid   one-cycle pulse, results valid in the same cycle
//   c_sign/c_bcd  Celsius sign and {hundreds,tens,ones,tenths}
//   f_sign/f_bcd  Fahrenheit sign and digits (same layout)
// -----------------------------------------------------------------------------
module temp_bcd_conv
   import temp_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [15:0]         raw,
   input  logic                raw_valid,
   output logic                busy,
   output logic                out_valid,
   output logic                c_sign,
   output logic [DIGITS*4-1:0] c_bcd,
   output logic                f_sign,
   output logic [DIGITS*4-1:0] f_bcd
);

   logic [2:0]          r_state;
   logic [2:0]          w_state_nxt;
   logic signed [12:0]  r_t16;
   logic                r_c_sign_h;
   logic                r_out_valid;
   logic                r_c_sign;
   logic [15:0]         r_c_bcd;

   logic [12:0]         w_mag;
   logic [16:0]         w_ct_sum;
   logic [16:0]         w_ct_sh;
   logic                w_dd_start;
   logic [12:0]         w_dd_bin;
   logic                w_dd_done;
   logic [15:0]         w_dd_bcd;
   logic                w_unused;

   // The three fractional bits below 1/16 C are not part of the reading
   assign w_unused = ^raw[2:0];

`ifdef TEMP_FAHRENHEIT_EN
   logic signed [17:0]  w_t18;
   logic signed [17:0]  w_prod;
   logic signed [17:0]  w_ft;
   logic [17:0]         w_ft_mag;
   logic                r_f_sign_h;
   logic [15:0]         r_c_bcd_h;
   logic                r_f_sign;
   logic [15:0]         r_f_bcd;
`endif

   // Celsius tenths: |t|*10 via shift-add, +8 then >>4 rounds half away
   // from zero because it is applied to the magnitude
   always_comb begin
      if (r_t16[12]) begin
         w_mag = 13'd0 - r_t16;
      end else begin
         w_mag = r_t16;
      end
      w_ct_sum = ({4'd0, w_mag} << 3) + ({4'd0, w_mag} << 1) + 17'(ROUND_HALF);
      w_ct_sh  = w_ct_sum >> 4;
   end

`ifdef TEMP_FAHRENHEIT_EN
   // Fahrenheit tenths: arithmetic shift on the signed product floors;
   // the 32.0 F offset is added after the division
   always_comb begin
      w_t18  = {{5{r_t16[12]}}, r_t16};
      w_prod = w_t18 * $signed(18'(F_MUL)) + $signed(18'(ROUND_HALF));
      w_ft   = (w_prod >>> 4) + $signed(18'(F_OFFSET_TENTHS));
      if (w_ft[17]) begin
         w_ft_mag = 18'd0 - w_ft;
      end else begin
         w_ft_mag = w_ft;
      end
   end
`endif

   // Shared BCD engine: loaded from PREP_C, and from PREP_F when present
   always_comb begin
`ifdef TEMP_FAHRENHEIT_EN
      w_dd_start = (r_state == ST_PREP_C) || (r_state == ST_PREP_F);
      if (r_state == ST_PREP_F) begin
         w_dd_bin = w_ft_mag[12:0];
      end else begin
         w_dd_bin = w_ct_sh[12:0];
      end
`else
      w_dd_start = (r_state == ST_PREP_C);
      w_dd_bin   = w_ct_sh[12:0];
`endif
   end

   bcd_dd13 u_dd (
      .clk   (clk),
      .rst_n (rst_n),
      .start (w_dd_start),
      .bin   (w_dd_bin),
      .done  (w_dd_done),
      .bcd   (w_dd_bcd)
   );

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (raw_valid) begin
               w_state_nxt = ST_PREP_C;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_PREP_C: w_state_nxt = ST_BCD_C;
         ST_BCD_C: begin
            if (w_dd_done) begin
`ifdef TEMP_FAHRENHEIT_EN
               w_state_nxt = ST_PREP_F;
`else
               w_state_nxt = ST_IDLE;
`endif
            end else begin
               w_state_nxt = ST_BCD_C;
            end
         end
`ifdef TEMP_FAHRENHEIT_EN
         ST_PREP_F: w_state_nxt = ST_BCD_F;
         ST_BCD_F: begin
            if (w_dd_done) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_BCD_F;
            end
         end
`endif
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Operand capture and Celsius sign (forced positive on zero magnitude)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_t16      <= 13'sd0;
         r_c_sign_h <= 1'b0;
      end else begin
         if ((r_state == ST_IDLE) && raw_valid) begin
            r_t16 <= raw[15:3];
         end
         if (r_state == ST_PREP_C) begin
            r_c_sign_h <= r_t16[12] && (w_ct_sh != 17'd0);
         end
      end
   end

`ifdef TEMP_FAHRENHEIT_EN
   // Intermediate holds so both scales reach the outputs on one edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_c_bcd_h  <= 16'd0;
         r_f_sign_h <= 1'b0;
      end else begin
         if ((r_state == ST_BCD_C) && w_dd_done) begin
            r_c_bcd_h <= w_dd_bcd;
         end
         if (r_state == ST_PREP_F) begin
            r_f_sign_h <= w_ft[17] && (w_ft_mag != 18'd0);
         end
      end
   end

   // Result registers: atomic update at the end of the Fahrenheit pass
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_c_sign    <= 1'b0;
         r_c_bcd     <= 16'd0;
         r_f_sign    <= 1'b0;
         r_f_bcd     <= 16'd0;
      end else begin
         r_out_valid <= 1'b0;
         if ((r_state == ST_BCD_F) && w_dd_done) begin
            r_out_valid <= 1'b1;
            r_c_sign    <= r_c_sign_h;
            r_c_bcd     <= r_c_bcd_h;
            r_f_sign    <= r_f_sign_h;
            r_f_bcd     <= w_dd_bcd;
         end
      end
   end

   assign f_sign = r_f_sign;
   assign f_bcd  = r_f_bcd;
`else
   // Result registers: update at the end of the Celsius pass
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_c_sign    <= 1'b0;
         r_c_bcd     <= 16'd0;
      end else begin
         r_out_valid <= 1'b0;
         if ((r_state == ST_BCD_C) && w_dd_done) begin
            r_out_valid <= 1'b1;
            r_c_sign    <= r_c_sign_h;
            r_c_bcd     <= w_dd_bcd;
         end
      end
   end

   assign f_sign = 1'b0;
   assign f_bcd  = 16'd0;
`endif

   assign busy      = (r_state != ST_IDLE);
   assign out_valid = r_out_valid;
   assign c_sign    = r_c_sign;
   assign c_bcd     = r_c_bcd;

endmodule

// File: tb/tb_temp_bcd_conv.sv
// -----------------------------------------------------------------------------
// tb_temp_bcd_conv
// Directed self-checking bench for temp_bcd_conv. Expected digits are
// hand-computed; Fahrenheit expectations apply when TEMP_FAHRENHEIT_EN is
// defined and are 0 otherwise.
// -----------------------------------------------------------------------------
module tb_temp_bcd_conv;
   import temp_pkg::*;

`ifdef TEMP_FAHRENHEIT_EN
   localparam bit F_EN = 1'b1;
   localparam int LAT  = LAT_CF;
`else
   localparam bit F_EN = 1'b0;
   localparam int LAT  = LAT_C;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] raw;
   logic        raw_valid;
   logic        busy;
   logic        out_valid;
   logic        c_sign;
   logic [15:0] c_bcd;
   logic        f_sign;
   logic [15:0] f_bcd;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] raw;
      logic        cs;
      logic [15:0] cb;
      logic        fs;
      logic [15:0] fb;
   } vec_t;

   vec_t vecs[11];

   temp_bcd_conv dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw       (raw),
      .raw_valid (raw_valid),
      .busy      (busy),
      .out_valid (out_valid),
      .c_sign    (c_sign),
      .c_bcd     (c_bcd),
      .f_sign    (f_sign),
      .f_bcd     (f_bcd)
   );

   always #5 clk = ~clk;

   // One-cycle strobe; returns at the falling edge after the sampling edge
   task automatic strobe(input logic [15:0] v);
      @(negedge clk);
      raw       = v;
      raw_valid = 1'b1;
      @(negedge clk);
      raw_valid = 1'b0;
   endtask

   // Count falling edges until out_valid is seen; -1 on timeout
   task automatic wait_valid(input int start, output int lat);
      lat = start;
      while (out_valid !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (out_valid !== 1'b1) lat = -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; raw = 16'h0000; raw_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, out_valid, c_sign, c_bcd, f_sign, f_bcd} !== 35'd0) begin
         errors++;
         $display("FAIL reset_in: got busy=%b ov=%b cs=%b cb=%h fs=%b fb=%h expected all 0",
                  busy, out_valid, c_sign, c_bcd, f_sign, f_bcd);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, out_valid, c_sign, c_bcd, f_sign, f_bcd} !== 35'd0) begin
         errors++;
         $display("FAIL reset_after: got busy=%b ov=%b cs=%b cb=%h expected all 0",
                  busy, out_valid, c_sign, c_bcd);
      end
   endtask

   task automatic test_conversions();
      int lat;
      logic        efs;
      logic [15:0] efb;
      for (int i = 0; i < 11; i++) begin
         efs = F_EN ? vecs[i].fs : 1'b0;
         efb = F_EN ? vecs[i].fb : 16'h0000;
         strobe(vecs[i].raw);
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL conv%0d busy_start: got %b expected 1", i, busy);
         end
         wait_valid(0, lat);
         checks++;
         if (lat !== LAT) begin
            errors++;
            $display("FAIL conv%0d latency: got %0d expected %0d", i, lat, LAT);
         end
         checks++;
         if (c_sign !== vecs[i].cs || c_bcd !== vecs[i].cb) begin
            errors++;
            $display("FAIL conv%0d celsius raw=%h: got %b/%h expected %b/%h",
                     i, vecs[i].raw, c_sign, c_bcd, vecs[i].cs, vecs[i].cb);
         end
         checks++;
         if (f_sign !== efs || f_bcd !== efb) begin
            errors++;
            $display("FAIL conv%0d fahrenheit raw=%h: got %b/%h expected %b/%h",
                     i, vecs[i].raw, f_sign, f_bcd, efs, efb);
         end
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL conv%0d busy_done: got %b expected 0", i, busy);
         end
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0 || c_bcd !== vecs[i].cb || f_bcd !== efb) begin
            errors++;
            $display("FAIL conv%0d hold: got ov=%b cb=%h fb=%h expected 0/%h/%h",
                     i, out_valid, c_bcd, f_bcd, vecs[i].cb, efb);
         end
      end
   endtask

   task automatic test_ignore_while_busy();
      int lat;
      int pulses;
      strobe(16'h0C80);
      repeat (4) @(negedge clk);
      raw = 16'h4B00; raw_valid = 1'b1;
      @(negedge clk);
      raw_valid = 1'b0;
      wait_valid(5, lat);
      checks++;
      if (lat !== LAT) begin
         errors++;
         $display("FAIL ignore latency: got %0d expected %0d", lat, LAT);
      end
      checks++;
      if (c_sign !== 1'b0 || c_bcd !== 16'h0250) begin
         errors++;
         $display("FAIL ignore result: got %b/%h expected 0/0250", c_sign, c_bcd);
      end
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid === 1'b1) pulses++;
      end
      checks++;
      if (pulses !== 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL ignore extra: got %0d pulses busy=%b expected 0 pulses busy=0", pulses, busy);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      int pulses;
      strobe(16'h4B00);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, out_valid, c_sign, c_bcd, f_sign, f_bcd} !== 35'd0) begin
         errors++;
         $display("FAIL midreset clear: got busy=%b ov=%b cs=%b cb=%h fs=%b fb=%h expected all 0",
                  busy, out_valid, c_sign, c_bcd, f_sign, f_bcd);
      end
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid === 1'b1) pulses++;
      end
      checks++;
      if (pulses !== 0 || c_bcd !== 16'h0000 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset quiet: got %0d pulses cb=%h busy=%b expected 0/0000/0", pulses, c_bcd, busy);
      end
      strobe(16'hE480);
      wait_valid(0, lat);
      checks++;
      if (lat !== LAT || c_sign !== 1'b1 || c_bcd !== 16'h0550) begin
         errors++;
         $display("FAIL midreset next: got lat=%0d %b/%h expected lat=%0d 1/0550", lat, c_sign, c_bcd, LAT);
      end
      checks++;
      if (f_sign !== F_EN || f_bcd !== (F_EN ? 16'h0670 : 16'h0000)) begin
         errors++;
         $display("FAIL midreset next_f: got %b/%h", f_sign, f_bcd);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      strobe(16'h0008);
      wait_valid(0, lat);
      // strobe issued in the out_valid cycle must be accepted
      raw = 16'hFFF8; raw_valid = 1'b1;
      @(negedge clk);
      raw_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || c_bcd !== 16'h0001 || c_sign !== 1'b0) begin
         errors++;
         $display("FAIL b2b accept: got busy=%b %b/%h expected busy=1 0/0001", busy, c_sign, c_bcd);
      end
      wait_valid(0, lat);
      checks++;
      if (lat !== LAT || c_sign !== 1'b1 || c_bcd !== 16'h0001) begin
         errors++;
         $display("FAIL b2b second: got lat=%0d %b/%h expected lat=%0d 1/0001", lat, c_sign, c_bcd, LAT);
      end
      checks++;
      if (f_sign !== 1'b0 || f_bcd !== (F_EN ? 16'h0319 : 16'h0000)) begin
         errors++;
         $display("FAIL b2b second_f: got %b/%h", f_sign, f_bcd);
      end
   endtask

   initial begin
      vecs[0]  = '{16'h0C80, 1'b0, 16'h0250, 1'b0, 16'h0770};
      vecs[1]  = '{16'hE480, 1'b1, 16'h0550, 1'b1, 16'h0670};
      vecs[2]  = '{16'h4B00, 1'b0, 16'h1500, 1'b0, 16'h3020};
      vecs[3]  = '{16'h0008, 1'b0, 16'h0001, 1'b0, 16'h0321};
      vecs[4]  = '{16'hFFF8, 1'b1, 16'h0001, 1'b0, 16'h0319};
      vecs[5]  = '{16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0320};
      vecs[6]  = '{16'h7FF8, 1'b0, 16'h2559, 1'b0, 16'h4927};
      vecs[7]  = '{16'h8000, 1'b1, 16'h2560, 1'b1, 16'h4288};
      vecs[8]  = '{16'h0020, 1'b0, 16'h0003, 1'b0, 16'h0325};
      vecs[9]  = '{16'hFFE0, 1'b1, 16'h0003, 1'b0, 16'h0316};
      vecs[10] = '{16'h0C87, 1'b0, 16'h0250, 1'b0, 16'h0770};

      test_reset();
      test_conversions();
      test_ignore_while_busy();
      test_reset_mid();
      test_back_to_back();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
